// File: rtl/chain_mixer_pkg.sv
// -----------------------------------------------------------------------------
// chain_mixer_pkg
//   Shared definitions for the chain mixer sequencer:
//     - state_e      : sequencer FSM states (IDLE, FILL, MIX, DONE)
//     - DEF_N_STAGES : default number of mixer stages in the chain
//     - DEF_CNT_W    : default width of the fill/mix dwell counters
// -----------------------------------------------------------------------------
package chain_mixer_pkg;

  localparam int DEF_N_STAGES = 32;
  localparam int DEF_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : chain_mixer_pkg

// File: rtl/chain_mixer_seq_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
//   Load-and-count-down timer shared by the FILL and MIX phases.
//   Ports:
//     clk      - clock, rising edge
//     rst_n    - asynchronous active-low reset
//     load     - load load_val (a value of 0 is treated as 1)
//     load_val - dwell length in cycles
//     expired  - high during the last cycle of the loaded dwell
//   The count stops at 1 instead of wrapping, so a dwell that is never reloaded
//   simply stays expired.
// -----------------------------------------------------------------------------
module dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      // A zero dwell still occupies one cycle of the phase.
      cnt_d = (load_val == '0) ? CNT_W'(1) : load_val;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The loaded value counts the cycle in which it is first visible, so the
  // phase ends when the remaining count reaches 1.
  assign expired = (cnt_q <= CNT_W'(1));

endmodule : dwell_timer

// File: rtl/chain_mixer_seq.sv
// -----------------------------------------------------------------------------
// chain_mixer_seq
//   Runs a chain of mixer stages in order. Each stage first opens its reagent
//   inlet valve for the fill dwell, then drives its mixer for the mix dwell.
//   After the last requested stage a one-cycle DONE state is entered.
//   Ports:
//     clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//     start        - request one sequence (only honoured in IDLE)
//     abort        - terminate a sequence that is in FILL or MIX
//     n_active     - number of stages to run (1..N_STAGES)
//     fill_cycles  - per-stage inlet open time (0 behaves as 1)
//     mix_cycles   - per-stage mixing time (0 behaves as 1)
//     k_valve      - one-hot inlet valve enables, registered
//     mix_en       - one-hot mixer enables, registered
//     stage_idx    - current stage index
//     busy         - high in FILL, MIX and DONE
//     done         - one-cycle pulse on normal completion (the DONE cycle)
//     aborted      - one-cycle pulse after an abort
//     cfg_err      - one-cycle pulse after a start with illegal n_active
//   All outputs are flops loaded from the next-state values, so they change
//   in the same cycle as the state they describe.
// -----------------------------------------------------------------------------
module chain_mixer_seq
  import chain_mixer_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [$clog2(N_STAGES+1)-1:0] n_active,
  input  logic [CNT_W-1:0]              fill_cycles,
  input  logic [CNT_W-1:0]              mix_cycles,
  output logic [N_STAGES-1:0]           k_valve,
  output logic [N_STAGES-1:0]           mix_en,
  output logic [$clog2(N_STAGES)-1:0]   stage_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic                          cfg_err
);

  localparam int NA_W = $clog2(N_STAGES + 1);
  localparam int SI_W = $clog2(N_STAGES);

  // ---------------------------------------------------------------------------
  // State and latched configuration
  // ---------------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic [SI_W-1:0]   stage_idx_q, stage_idx_d;
  logic [NA_W-1:0]   n_lat_q,     n_lat_d;
  logic [CNT_W-1:0]  fill_lat_q,  fill_lat_d;
  logic [CNT_W-1:0]  mix_lat_q,   mix_lat_d;

  // Registered outputs
  logic [N_STAGES-1:0] k_valve_q, k_valve_d;
  logic [N_STAGES-1:0] mix_en_q,  mix_en_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic                aborted_q, aborted_d;
  logic                cfg_err_q, cfg_err_d;

  // Shared dwell timer control
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expired;

  logic             n_invalid;
  logic             last_stage;
  logic [N_STAGES-1:0] stage_hot;

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  assign n_invalid  = (n_active == '0) || (n_active > NA_W'(N_STAGES));
  assign last_stage = (NA_W'(stage_idx_q) == (n_lat_q - NA_W'(1)));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    stage_idx_d = stage_idx_q;
    n_lat_d     = n_lat_q;
    fill_lat_d  = fill_lat_q;
    mix_lat_d   = mix_lat_q;
    tmr_load    = 1'b0;
    tmr_val     = fill_lat_q;
    aborted_d   = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort has no meaning here, so a simultaneous start always wins.
        if (start) begin
          if (n_invalid) begin
            cfg_err_d = 1'b1;
          end else begin
            n_lat_d     = n_active;
            fill_lat_d  = fill_cycles;
            mix_lat_d   = mix_cycles;
            stage_idx_d = '0;
            state_d     = ST_FILL;
            // Load straight from the port: the latch is not visible yet.
            tmr_load    = 1'b1;
            tmr_val     = fill_cycles;
          end
        end
      end

      ST_FILL: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (tmr_expired) begin
          state_d  = ST_MIX;
          tmr_load = 1'b1;
          tmr_val  = mix_lat_q;
        end
      end

      ST_MIX: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (tmr_expired) begin
          if (last_stage) begin
            state_d = ST_DONE;
          end else begin
            stage_idx_d = stage_idx_q + SI_W'(1);
            state_d     = ST_FILL;
            tmr_load    = 1'b1;
            tmr_val     = fill_lat_q;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so the registered outputs line up with
  // the state they belong to.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage_dec
    assign stage_hot[gi] = (stage_idx_d == SI_W'(gi));
  end

  always_comb begin
    k_valve_d = '0;
    mix_en_d  = '0;
    if (state_d == ST_FILL) begin
      k_valve_d = stage_hot;
    end
    if (state_d == ST_MIX) begin
      mix_en_d = stage_hot;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      stage_idx_q <= '0;
      n_lat_q     <= '0;
      fill_lat_q  <= '0;
      mix_lat_q   <= '0;
      k_valve_q   <= '0;
      mix_en_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_idx_q <= stage_idx_d;
      n_lat_q     <= n_lat_d;
      fill_lat_q  <= fill_lat_d;
      mix_lat_q   <= mix_lat_d;
      k_valve_q   <= k_valve_d;
      mix_en_q    <= mix_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign k_valve   = k_valve_q;
  assign mix_en    = mix_en_q;
  assign stage_idx = stage_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign cfg_err   = cfg_err_q;

endmodule : chain_mixer_seq

// File: tb/tb_chain_mixer_seq.sv
// -----------------------------------------------------------------------------
// tb_chain_mixer_seq
//   Directed scenarios plus random traffic for chain_mixer_seq. The reference
//   model tracks only "active" and the cycle number c since accept; expected
//   outputs are derived arithmetically: with F=max(fill,1), M=max(mix,1),
//   P=F+M, cycle c (1-based) belongs to stage (c-1)/P and is a fill cycle when
//   (c-1)%P < F; cycle n*P+1 is the done cycle.
// -----------------------------------------------------------------------------
module tb_chain_mixer_seq;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [5:0]  n_active = '0;
  logic [15:0] fill_cycles = '0;
  logic [15:0] mix_cycles = '0;
  logic [31:0] k_valve;
  logic [31:0] mix_en;
  logic [4:0]  stage_idx;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        cfg_err;

  always #5 clk = ~clk;

  chain_mixer_seq #(
    .N_STAGES (32),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .n_active    (n_active),
    .fill_cycles (fill_cycles),
    .mix_cycles  (mix_cycles),
    .k_valve     (k_valve),
    .mix_en      (mix_en),
    .stage_idx   (stage_idx),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .cfg_err     (cfg_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit m_active = 1'b0;
  bit m_abt    = 1'b0;
  bit m_cfg    = 1'b0;
  int m_c = 0;
  int m_n = 0;
  int m_f = 1;
  int m_m = 1;

  task automatic model_reset();
    m_active = 1'b0;
    m_c      = 0;
    m_abt    = 1'b0;
    m_cfg    = 1'b0;
  endtask

  function automatic int seq_len();
    return m_n * (m_f + m_m);
  endfunction

  // Applied at every rising edge using the inputs held across that edge.
  task automatic model_edge();
    m_abt = 1'b0;
    m_cfg = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_active) begin
      if (start) begin
        if (int'(n_active) >= 1 && int'(n_active) <= N) begin
          m_active = 1'b1;
          m_c      = 1;
          m_n      = int'(n_active);
          m_f      = (fill_cycles == 0) ? 1 : int'(fill_cycles);
          m_m      = (mix_cycles == 0) ? 1 : int'(mix_cycles);
        end else begin
          m_cfg = 1'b1;
        end
      end
    end else if (m_c <= seq_len() && abort) begin
      m_active = 1'b0;
      m_abt    = 1'b1;
    end else if (m_c == seq_len() + 1) begin
      m_active = 1'b0;
    end else begin
      m_c++;
    end
  endtask

  function automatic int cur_stage();
    return (m_c - 1) / (m_f + m_m);
  endfunction

  function automatic bit in_fill();
    return ((m_c - 1) % (m_f + m_m)) < m_f;
  endfunction

  task automatic compare_all();
    logic [31:0] ek = '0;
    logic [31:0] em = '0;
    bit work;
    bit excl;
    work = m_active && (m_c <= seq_len());
    if (work) begin
      if (in_fill()) ek = 32'd1 << cur_stage();
      else           em = 32'd1 << cur_stage();
      check_val("stage_idx", stage_idx, cur_stage());
    end
    check_val("k_valve", k_valve, ek);
    check_val("mix_en", mix_en, em);
    check_val("busy", busy, m_active);
    check_val("done", done, m_active && (m_c == seq_len() + 1));
    check_val("aborted", aborted, m_abt);
    check_val("cfg_err", cfg_err, m_cfg);
    excl = ((k_valve != 0) && (mix_en != 0)) || !$onehot0(k_valve) || !$onehot0(mix_en);
    check_val("valve_exclusive", excl, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val("rst_stage_idx", stage_idx, 0);
    repeat (2) tick();
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic launch(input int n, input int f, input int m);
    n_active    = 6'(n);
    fill_cycles = 16'(f);
    mix_cycles  = 16'(m);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  int lat;
  bit reached;

  initial begin
    // Reset state
    #1;
    model_reset();
    compare_all();
    check_val("rst_stage_idx", stage_idx, 0);
    repeat (2) tick();
    #3;
    rst_n = 1'b1;
    tick();

    // Scenario 1: 3 stages, fill 2, mix 4 -> done in cycle 19 after accept
    launch(3, 2, 4);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check_val("s1_done_latency", lat, 19);
    repeat (3) tick();

    // Scenario 2: all 32 stages with zero dwells -> done in cycle 65
    launch(32, 0, 0);
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check_val("s2_done_latency", lat, 65);
    repeat (3) tick();

    // Scenario 3: abort during MIX of stage 5
    launch(8, 3, 5);
    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      if (m_active && m_c <= seq_len() && cur_stage() == 5 && !in_fill() &&
          ((m_c - 1) % (m_f + m_m)) >= m_f + 1)
        reached = 1'b1;
      else
        tick();
    end
    check_val("s3_reach_mix5", reached, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("s3_aborted_pulse", aborted, 1'b1);
    repeat (4) tick();

    // Scenario 4: illegal n_active values
    launch(0, 2, 2);
    repeat (2) tick();
    launch(33, 2, 2);
    repeat (3) tick();

    // Scenario 5: asynchronous reset during FILL of stage 2, then fresh run
    launch(4, 3, 2);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (m_active && m_c <= seq_len() && cur_stage() == 2 && in_fill())
        reached = 1'b1;
      else
        tick();
    end
    check_val("s5_reach_fill2", reached, 1'b1);
    async_reset();
    launch(2, 1, 1);
    check_val("s5_restart_k0", k_valve, 32'd1);
    repeat (8) tick();

    // Scenario 6: start re-pulsed and config scrambled mid-run
    launch(4, 3, 3);
    lat = 1;
    while (!done && lat < 60) begin
      start       = 1'($urandom_range(1, 0));
      n_active    = 6'($urandom_range(33, 0));
      fill_cycles = 16'($urandom);
      mix_cycles  = 16'($urandom);
      tick();
      lat++;
    end
    start = 1'b0;
    check_val("s6_done_latency", lat, 25);
    repeat (3) tick();

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      start       = ($urandom_range(3, 0) == 0);
      abort       = ($urandom_range(39, 0) == 0);
      n_active    = ($urandom_range(9, 0) == 0) ? 6'($urandom_range(33, 0))
                                                : 6'($urandom_range(6, 1));
      fill_cycles = 16'($urandom_range(3, 0));
      mix_cycles  = 16'($urandom_range(3, 0));
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_chain_mixer_seq

// File: doc/chain_mixer_seq.md
CHAIN_MIXER_SEQ -- requirements
Module: chain_mixer_seq

Interface
REQ-001 The module SHALL have parameter N_STAGES, default 32, giving the number of mixer stages in the chain.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the width of the fill and mix dwell counters.
REQ-003 Port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 Port start, input, 1, request to run one chain sequence.
REQ-006 Port abort, input, 1, request to terminate a running sequence.
REQ-007 Port n_active, input, $clog2(N_STAGES+1), number of stages to run.
REQ-008 Port fill_cycles, input, CNT_W, per-stage reagent inlet open time.
REQ-009 Port mix_cycles, input, CNT_W, per-stage mixing time.
REQ-010 Port k_valve, output, N_STAGES, one-hot reagent inlet valve enables (k0..kN-1).
REQ-011 Port mix_en, output, N_STAGES, one-hot mixer actuation enables (m0..mN-1).
REQ-012 Port stage_idx, output, $clog2(N_STAGES), current stage index.
REQ-013 Port busy, input-independent output, 1, high from sequence accept until return to IDLE.
REQ-014 Port done, output, 1, one-cycle pulse on normal completion.
REQ-015 Port aborted, output, 1, one-cycle pulse on abort completion.
REQ-016 Port cfg_err, output, 1, one-cycle pulse when start is rejected for n_active of 0 or greater than N_STAGES.

Function
REQ-017 FSM states SHALL be IDLE, FILL, MIX, and DONE.
REQ-018 In IDLE, on start with valid n_active, the block SHALL latch n_active, fill_cycles, and mix_cycles, clear stage_idx, and enter FILL the next cycle.
REQ-019 On start with invalid n_active, the block SHALL stay in IDLE and pulse cfg_err for one cycle.
REQ-020 In FILL, k_valve[stage_idx] SHALL be the only bit set, for exactly max(fill_cycles,1) cycles; the block then enters MIX.
REQ-021 In MIX, mix_en[stage_idx] SHALL be the only bit set, for exactly max(mix_cycles,1) cycles.
REQ-022 At the end of MIX, if stage_idx equals latched n_active-1, the block SHALL enter DONE; otherwise it SHALL increment stage_idx and enter FILL.
REQ-023 DONE SHALL last one cycle, assert done, and return to IDLE.
REQ-024 k_valve and mix_en SHALL never both be nonzero in the same cycle; at most one bit of each SHALL be set.
REQ-025 busy SHALL be high in FILL, MIX, and DONE, and low in IDLE.
REQ-026 start SHALL be ignored while busy.
REQ-027 Config inputs changing mid-sequence SHALL have no effect.
REQ-028 abort in FILL or MIX SHALL clear all valves the next cycle, pulse aborted, skip done, and return to IDLE.
REQ-029 abort in IDLE or DONE SHALL be ignored; when start and abort arrive in the same IDLE cycle, start SHALL win.
REQ-030 Dwell counters SHALL count down from the latched value with no wrap; the total sequence length SHALL be n_active*(max(fill,1)+max(mix,1))+1 cycles after accept.

Reset
REQ-031 On rst_n low, the block SHALL immediately enter IDLE and force k_valve=0, mix_en=0, stage_idx=0, busy=0, done=0, aborted=0, and cfg_err=0, including mid-sequence; no pulse SHALL follow reset release.

Structure
REQ-032 Package chain_mixer_pkg SHALL hold the FSM state enum and the default N_STAGES and CNT_W constants.
REQ-033 A single sub-module, dwell_timer (load, count-down, expire flag, CNT_W wide), SHALL be shared by FILL and MIX.
REQ-034 Valve outputs SHALL be registered, with one-hot decode from stage_idx.

Verification
REQ-035 Scenario 1: n_active=3, fill=2, mix=4, start pulse -> k0 for 2 cycles, m0 for 4, then k1, m1, k2, m2; done pulses 19 cycles after accept.
REQ-036 Scenario 2: n_active=32, fill=0, mix=0 -> every stage has 1-cycle fill and 1-cycle mix; stage_idx reaches 31; done follows at cycle 65.
REQ-037 Scenario 3: abort during MIX of stage 5 -> valves are 0 next cycle, aborted pulses once, done stays 0, busy drops.
REQ-038 Scenario 4: start with n_active=0 and with n_active=33 -> cfg_err pulses each time, busy stays 0, valves stay 0.
REQ-039 Scenario 5: rst_n low during FILL of stage 2 -> all outputs are 0 asynchronously; after release, a fresh start runs from stage 0.
REQ-040 Scenario 6: start re-pulsed and config changed mid-run -> the sequence timing is unchanged; a continuous assertion checks that k_valve and mix_en are never simultaneously nonzero and are each at most one-hot.
